ans_count_sender: RTL and testbench

Builds a symbol histogram from an incoming symbol stream, then transmits the resulting count table, one count per transfer, over the same valid/ready count-load handshake that the ANS count loader receives. It is the transmit end of the count-table link. It sits between the symbol source and the loader, so a table can be generated on-chip instead of being driven from pins. After the table is sent, it clears itself and is ready for the next block of symbols.

---
 rtl/ans_count_if.sv | 41 ++++
 rtl/ans_count_sender.sv | 104 ++++++++++
 tb/tb_ans_count_sender.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ans_count_if.sv
// ans_count_if: symbol-stream input and count-table output of ans_count_sender.
//
// Signals:
//   sym_in, sym_vld, sym_last : symbol stream into the histogram (no backpressure)
//   sym_rdy                   : sender is accepting symbols
//   out, out_vld, out_rdy     : count-table transfer toward the count loader
//   done                      : one-cycle pulse after the final count transfers
//
// Modports:
//   master : the count sender itself
//   slave  : the environment (symbol source plus count receiver)
`ifndef SYM_WIDTH
`define SYM_WIDTH 4
`endif
`ifndef CNT_WIDTH
`define CNT_WIDTH 8
`endif

interface ans_count_if #(
    parameter int SYM_WIDTH = `SYM_WIDTH,
    parameter int CNT_WIDTH = `CNT_WIDTH
);
    logic [SYM_WIDTH-1:0] sym_in;
    logic                 sym_vld;
    logic                 sym_last;
    logic                 sym_rdy;
    logic [CNT_WIDTH-1:0] out;
    logic                 out_vld;
    logic                 out_rdy;
    logic                 done;

    modport master (
        input  sym_in, sym_vld, sym_last, out_rdy,
        output sym_rdy, out, out_vld, done
    );

    modport slave (
        output sym_in, sym_vld, sym_last, out_rdy,
        input  sym_rdy, out, out_vld, done
    );
endinterface

// File: rtl/ans_count_sender.sv
// ans_count_sender: builds a saturating symbol histogram from a symbol stream,
// then sends the 2**SYM_WIDTH counts one per valid/ready transfer, with a
// one-cycle valid-low gap between words so the count loader can re-arm its
// ready. After the final word the table clears and counting resumes.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ans_count_if.master (symbol input, count output, done pulse)
//
// state | meaning
// ------+--------------------------------------------------------------
// COUNT | accepting symbols, sym_rdy=1; sym_last moves to SEND
// SEND  | offering count[idx] with out_vld=1 until out_rdy
// GAP   | out_vld=0 for one cycle between words, then back to SEND
`ifndef SYM_WIDTH
`define SYM_WIDTH 4
`endif
`ifndef CNT_WIDTH
`define CNT_WIDTH 8
`endif

module ans_count_sender #(
    parameter int SYM_WIDTH = `SYM_WIDTH,
    parameter int CNT_WIDTH = `CNT_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    ans_count_if.master bus
);
    localparam int N = 2 ** SYM_WIDTH;
    localparam logic [CNT_WIDTH-1:0] MAX      = '1;
    localparam logic [SYM_WIDTH-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {COUNT, SEND, GAP} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] counts [N];
    logic [SYM_WIDTH-1:0] idx;
    logic [SYM_WIDTH-1:0] idx_nxt;

    // Only used below LAST_IDX, so it never wraps.
    assign idx_nxt = idx + 1'b1;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COUNT;
            idx         <= '0;
            for (int i = 0; i < N; i++) counts[i] <= '0;
            bus.sym_rdy <= 1'b1;
            bus.out_vld <= 1'b0;
            bus.out     <= '0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                COUNT: begin
                    if (bus.sym_vld) begin
                        counts[bus.sym_in] <= sat_inc(counts[bus.sym_in]);
                        if (bus.sym_last) begin
                            state       <= SEND;
                            idx         <= '0;
                            bus.sym_rdy <= 1'b0;
                            bus.out_vld <= 1'b1;
                            // out is registered, so fold in the increment
                            // landing on this same edge when it hits entry 0.
                            bus.out     <= (bus.sym_in == '0) ? sat_inc(counts[0]) : counts[0];
                        end
                    end
                end
                SEND: begin
                    if (bus.out_rdy) begin
                        bus.out_vld <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state       <= COUNT;
                            idx         <= '0;
                            for (int i = 0; i < N; i++) counts[i] <= '0;
                            bus.sym_rdy <= 1'b1;
                            bus.out     <= '0;
                            bus.done    <= 1'b1;
                        end else begin
                            state   <= GAP;
                            idx     <= idx_nxt;
                            // Counts are frozen here, so the next word can be
                            // staged during the gap.
                            bus.out <= counts[idx_nxt];
                        end
                    end
                end
                GAP: begin
                    state       <= SEND;
                    bus.out_vld <= 1'b1;
                end
                default: begin
                    state <= COUNT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ans_count_sender.sv
module tb_ans_count_sender;
    localparam int SW   = 4;
    localparam int CW   = 8;
    localparam int N    = 16;
    localparam int MAXC = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ans_count_if #(.SYM_WIDTH(SW), .CNT_WIDTH(CW)) bus ();

    ans_count_sender #(.SYM_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int sym;
        bit vld;
        bit last;
        bit exp_rdy;
    } vec_t;

    vec_t vecs [6];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   model [N];
    bit   counting = 1'b1;
    int   got   [N];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) model[i] = 0;
        counting = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.sym_in   = '0;
        bus.sym_vld  = 1'b0;
        bus.sym_last = 1'b0;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic send_sym(input int s, input bit v, input bit l);
        bus.sym_in   = s[SW-1:0];
        bus.sym_vld  = v;
        bus.sym_last = l;
        if (v && counting) begin
            if (model[s] < MAXC) model[s]++;
            if (l) counting = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Receives one table. loader=1 emulates the count loader's ready
    // protocol; hold_at stalls ready for 10 cycles at that word; abort_at
    // resets at that word; junk drives symbols while the table is sent.
    task automatic collect(input string tag, input bit loader, input int hold_at,
                           input int abort_at, input bit junk, input bit check_once);
        int   k = 0;
        int   samples = 0;
        bit   started = 1'b0;
        bit   held = 1'b0;
        bit   finished = 1'b0;
        bit   xfer;
        logic rdy_next;
        int   saved;
        bus.out_rdy = 1'b1;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            check({tag, " no early done"}, int'(bus.done), 0);
            if (hold_at == k && bus.out_vld && !held) begin
                held = 1'b1;
                saved = int'(bus.out);
                bus.out_rdy = 1'b0;
                for (int h = 0; h < 10; h++) begin
                    @(posedge clk);
                    @(negedge clk);
                    check({tag, " hold out_vld"}, int'(bus.out_vld), 1);
                    check({tag, " hold out"}, int'(bus.out), saved);
                end
                bus.out_rdy = 1'b1;
            end
            if (abort_at == k && bus.out_vld) begin
                rst_n = 1'b0;
                #1;
                check({tag, " reset out_vld"}, int'(bus.out_vld), 0);
                check({tag, " reset sym_rdy"}, int'(bus.sym_rdy), 1);
                check({tag, " reset done"}, int'(bus.done), 0);
                model_clear();
                idle_inputs();
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                bus.out_rdy = 1'b1;
                return;
            end
            xfer = bus.out_vld && bus.out_rdy;
            if (bus.out_vld) started = 1'b1;
            if (started && k < N) samples++;
            if (xfer) begin
                got[k] = int'(bus.out);
                k++;
            end
            rdy_next = xfer ? 1'b0 : ((!bus.out_rdy && !bus.out_vld) ? 1'b1 : bus.out_rdy);
            if (junk) begin
                bus.sym_vld  = 1'b1;
                bus.sym_in   = 4'($urandom_range(0, 15));
                bus.sym_last = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            if (loader) bus.out_rdy = rdy_next;
            @(negedge clk);
            if (k == N) begin
                check({tag, " done pulse"}, int'(bus.done), 1);
                check({tag, " sym_rdy at done"}, int'(bus.sym_rdy), 1);
                check({tag, " out_vld at done"}, int'(bus.out_vld), 0);
                finished = 1'b1;
            end
        end
        idle_inputs();
        bus.out_rdy = 1'b1;
        if (!finished) begin
            check({tag, " table complete before timeout"}, k, N);
            return;
        end
        for (int i = 0; i < N; i++)
            check($sformatf("%s count[%0d]", tag, i), got[i], model[i]);
        if (hold_at < 0)
            check({tag, " edges first valid to last transfer"}, samples, 2 * N - 1);
        model_clear();
        if (check_once) begin
            @(negedge clk);
            check({tag, " done single pulse"}, int'(bus.done), 0);
        end
    endtask

    initial begin
        vecs[0] = '{sym: 3, vld: 1'b1, last: 1'b0, exp_rdy: 1'b1};
        vecs[1] = '{sym: 3, vld: 1'b1, last: 1'b0, exp_rdy: 1'b1};
        vecs[2] = '{sym: 7, vld: 1'b1, last: 1'b0, exp_rdy: 1'b1};
        vecs[3] = '{sym: 9, vld: 1'b0, last: 1'b1, exp_rdy: 1'b1};
        vecs[4] = '{sym: 3, vld: 1'b1, last: 1'b0, exp_rdy: 1'b1};
        vecs[5] = '{sym: 0, vld: 1'b1, last: 1'b1, exp_rdy: 1'b0};

        idle_inputs();
        bus.out_rdy = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        check("reset sym_rdy", int'(bus.sym_rdy), 1);
        check("reset out_vld", int'(bus.out_vld), 0);
        check("reset out", int'(bus.out), 0);
        check("reset done", int'(bus.done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Histogram and send, receiver always ready.
        for (int i = 0; i < 6; i++) begin
            send_sym(vecs[i].sym, vecs[i].vld, vecs[i].last);
            check($sformatf("vec%0d sym_rdy", i), int'(bus.sym_rdy), int'(vecs[i].exp_rdy));
        end
        idle_inputs();
        check("first out_vld", int'(bus.out_vld), 1);
        check("first out", int'(bus.out), 1);
        collect("hist", 1'b0, -1, -1, 1'b0, 1'b1);
        check("hist const count[0]", got[0], 1);
        check("hist const count[3]", got[3], 3);
        check("hist const count[7]", got[7], 1);
        check("hist const count[9]", got[9], 0);

        // Loopback against the loader's ready protocol.
        send_sym(1, 1'b1, 1'b0);
        send_sym(2, 1'b1, 1'b0);
        send_sym(2, 1'b1, 1'b0);
        send_sym(15, 1'b1, 1'b1);
        idle_inputs();
        collect("loop", 1'b1, -1, -1, 1'b0, 1'b1);
        check("loop const count[1]", got[1], 1);
        check("loop const count[2]", got[2], 2);
        check("loop const count[15]", got[15], 1);

        // Saturation.
        for (int i = 0; i < 300; i++) send_sym(5, 1'b1, 1'b0);
        send_sym(6, 1'b1, 1'b1);
        idle_inputs();
        collect("sat", 1'b0, -1, -1, 1'b0, 1'b1);
        check("sat const count[5]", got[5], 255);
        check("sat const count[6]", got[6], 1);

        // Backpressure at idx 4.
        send_sym(3, 1'b1, 1'b0);
        send_sym(4, 1'b1, 1'b0);
        send_sym(4, 1'b1, 1'b1);
        idle_inputs();
        collect("bp", 1'b0, 4, -1, 1'b0, 1'b1);
        check("bp const count[4]", got[4], 2);

        // Back-to-back blocks with symbols driven during SEND.
        send_sym(8, 1'b1, 1'b0);
        send_sym(8, 1'b1, 1'b0);
        send_sym(2, 1'b1, 1'b1);
        idle_inputs();
        collect("b2b_a", 1'b0, -1, -1, 1'b1, 1'b0);
        send_sym(1, 1'b1, 1'b0);
        send_sym(1, 1'b1, 1'b1);
        idle_inputs();
        collect("b2b_b", 1'b1, -1, -1, 1'b0, 1'b1);
        check("b2b const count[1]", got[1], 2);
        check("b2b const count[8]", got[8], 0);

        // Reset in the middle of the table.
        send_sym(9, 1'b1, 1'b0);
        send_sym(9, 1'b1, 1'b0);
        send_sym(10, 1'b1, 1'b1);
        idle_inputs();
        collect("abort", 1'b0, -1, 9, 1'b0, 1'b0);
        send_sym(11, 1'b1, 1'b1);
        idle_inputs();
        collect("post_reset", 1'b0, -1, -1, 1'b0, 1'b1);
        check("post_reset const count[9]", got[9], 0);
        check("post_reset const count[11]", got[11], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
